dpram_burst_reader: RTL and testbench
=====================================

Name: dpram_burst_reader

Overview:
Read-side engine for the inferred dual-port RAM line buffers in the SDRAM path. It accepts a burst command (start address, word count) and drives one RAM port's address. It captures RAM read data, which has one clock of latency, and streams the words out on a valid/ready interface with full backpressure support. It is the consumer counterpart to the SDRAM fill logic that writes the buffer through the other port.

Parameters:
depth, 8, RAM address width in bits; buffer holds 2^depth words
width, 32, data word width in bits

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  engine can accept command (high only in IDLE)
cmd_addr  input  depth  first word address
cmd_len  input  depth+1  word count, 0..2^depth
ram_address  output  depth  registered address to RAM port (connects to address_x)
ram_q  input  width  RAM read data, valid one clock after ram_address is sampled
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts word
out_data  output  width  stream data
out_last  output  1  qualifies the final word of the burst
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when burst fully delivered (or a len=0 command is accepted)

Behaviour:
- Reset values: state IDLE; cmd_ready=1; ram_address=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; FIFO empty; inflight=0; remaining=0.
- Reset mid-burst aborts immediately. No further words are emitted, and no done pulse is generated.
- The RAM write-enable for this port is tied low by the integrator; this block never writes.
- States:
  - IDLE: on cmd_valid & cmd_ready, load rd_ptr=cmd_addr and remaining=cmd_len. If cmd_len==0, pulse done next cycle and stay IDLE; otherwise go to RUN.
  - RUN: issue reads until remaining==0, then go to DRAIN.
  - DRAIN: when FIFO empty and inflight==0, go to IDLE and pulse done in the same cycle as the transition.
- ram_address = rd_ptr (registered).
- Issue condition: issue = (state==RUN) & (remaining!=0) & (fifo_count + inflight - pop < 2), where pop = out_valid & out_ready. The combinational path from out_ready to issue is allowed.
- On issue:
  - rd_ptr increments modulo 2^depth; the address after 2^depth-1 is 0.
  - remaining decrements.
  - inflight<=1 and tag_last<=(remaining==1).
  - When not issuing, inflight<=0.
- Capture: while inflight==1, push {tag_last, ram_q} into a 2-entry FIFO at the next edge. The RAM q for the address presented in cycle t is valid in cycle t+1.
- Output: out_valid = FIFO not empty; out_data and out_last come from the FIFO head. Simultaneous push and pop is legal, and the count is unchanged.
- The credit rule guarantees no FIFO overflow. Any push while full is a design error; the bench asserts it never happens.
- Throughput: with out_ready held high, one word per clock after a first-word latency of 3 clocks from command acceptance (accept → first ram_address edge → capture → out_valid).
- Back-to-back: a new command can be accepted the cycle after done.
- Data stability: out_data and out_last hold stable while out_valid & !out_ready.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RUN=1, DRAIN=2) and a function computing the credit check.
- One sub-module, dpram_skid_fifo:
  - 2-entry, width+1 bits wide.
  - Ports: push, pop, din, dout, count, empty, full.
  - Same clock and reset.

Test Plan:
- Basic burst: addr=0x10, len=4, RAM preloaded mem[i]=i*0x01010101, out_ready=1 → words 0x10101010..0x13131313 on consecutive cycles; out_last on the 4th; done one cycle after the last handshake; first out_valid 3 clocks after acceptance.
- Backpressure: len=8, out_ready toggled 1,0,0,1,... → all 8 words in order; none dropped or duplicated; out_data stable while stalled; FIFO count never exceeds 2.
- Zero length: cmd_len=0 → no out_valid; done pulses one cycle after acceptance; busy never asserts.
- Wrap and full buffer: addr=0xFE, len=4 → data from 0xFE, 0xFF, 0x00, 0x01. Also len=256 from addr=0 → all 256 words, out_last on word 255.
- Reset mid-burst: len=16, assert reset after 5 words → outputs return to reset values asynchronously. A following command addr=0x20, len=2 yields mem[0x20], mem[0x21] only.
- Back-to-back commands: cmd_valid held with a second command queued → second burst starts after the first done; no gap words; the out_last count equals the command count.

Source files
------------

// File: rtl/dpram_burst_reader_pkg.sv
// Shared state encoding and the read-credit check for the dual-port RAM burst reader.
package dpram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A read may be issued only if the word it returns is guaranteed a FIFO slot.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] level;
    level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return level < 3'd2;
  endfunction

endpackage

// File: rtl/dpram_skid_fifo.sv
// Two-entry FIFO that catches RAM read data so the output stream can stall freely.
module dpram_skid_fifo #(
  parameter int dw = 33
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [dw-1:0] din,
  output logic [dw-1:0] dout,
  output logic [1:0]    count,
  output logic          empty,
  output logic          full
);

  logic [dw-1:0] mem_q [2];
  logic [dw-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read engine: walks one RAM port from a start address and streams the
// words out over valid/ready, absorbing the one-clock RAM read latency.
module dpram_burst_reader
  import dpram_burst_reader_pkg::*;
#(
  parameter int depth = 8,
  parameter int width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [depth-1:0] cmd_addr,
  input  logic [depth:0]   cmd_len,
  output logic [depth-1:0] ram_address,
  input  logic [width-1:0] ram_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [depth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [depth:0]     remaining_q, remaining_d;
  logic               inflight_q, inflight_d;
  logic               tag_last_q, tag_last_d;
  logic               zero_done_q, zero_done_d;
  logic               drain_done;
  logic               issue;
  logic               pop;
  logic [width:0]     fifo_dout;
  logic [1:0]         fifo_count;
  logic               fifo_empty;
  logic               fifo_full;

  assign pop = out_valid & out_ready;
  // The full term is redundant with the credit check; it keeps a stray issue from ever overrunning the FIFO.
  assign issue = (state_q == RUN) && (remaining_q != '0)
               && credit_ok(fifo_count, inflight_q, pop) && !(fifo_full && !pop);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    tag_last_d  = tag_last_q;
    zero_done_d = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_ptr_d    = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + depth'(1);
          remaining_d = remaining_q - (depth+1)'(1);
          inflight_d  = 1'b1;
          tag_last_d  = (remaining_q == (depth+1)'(1));
        end
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      tag_last_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      tag_last_q  <= tag_last_d;
      zero_done_q <= zero_done_d;
    end
  end

  dpram_skid_fifo #(
    .dw(width + 1)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({tag_last_q, ram_q}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ram_address = rd_ptr_q;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = drain_done | zero_done_q;
  assign out_valid   = !fifo_empty;
  assign out_last    = fifo_dout[width];
  assign out_data    = fifo_dout[width-1:0];

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader with a registered-read RAM model.
module tb_dpram_burst_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = 8'h00;
  logic [8:0]  cmd_len = 9'd0;
  logic [7:0]  ram_address;
  logic [31:0] ram_q = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  logic [32:0] rx_q [$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int accept_cyc = -1;
  int first_valid_cyc = -1;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int done_count = 0;
  int last_cnt = 0;
  int stable_err = 0;
  int overflow_err = 0;
  int max_cnt = 0;
  bit busy_seen = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_last = 1'b0;

  dpram_burst_reader #(
    .depth(8),
    .width(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    ram_q <= mem[ram_address];
  end

  // Consumer: always ready, or the 1,0,0,1 pattern for backpressure.
  always @(posedge clock) begin
    #1;
    if (rdy_mode == 0) begin
      out_ready = 1'b1;
    end else begin
      case (cyc % 4)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (out_data !== prev_data || out_last !== prev_last || !out_valid))
        stable_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        rx_q.push_back({out_last, out_data});
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (out_last) last_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        done_count++;
      end
      if (busy) busy_seen = 1;
      if (cmd_valid && cmd_ready) accept_cyc = cyc;
      if (dut.u_fifo.push && dut.u_fifo.full) overflow_err++;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    rx_q.delete();
    first_valid_cyc = -1;
    first_hs_cyc    = -1;
    last_hs_cyc     = -1;
    last_cnt        = 0;
    stable_err      = 0;
    busy_seen       = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic do_cmd(input logic [7:0] addr, input logic [8:0] len);
    bit ok;
    ok = 0;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    check("cmd_accept", ok, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      #1;
      if (done_count >= target) begin
        ok = 1;
        break;
      end
    end
    check("done_seen", ok, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic verify_burst(input logic [7:0] addr, input int start, input int len);
    logic [7:0]  a;
    logic [32:0] w;
    for (int i = 0; i < len && (start + i) < rx_q.size(); i++) begin
      a = addr + 8'(i);
      w = rx_q[start + i];
      check("data", w[31:0], mem[a]);
      check("last", w[32], (i == len - 1));
    end
    $display("burst addr=%02h len=%0d words_rx=%0d lasts=%0d", addr, len, rx_q.size(), last_cnt);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ram_address", ram_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic burst
    clear_stats();
    d0 = done_count;
    do_cmd(8'h10, 9'd4);
    wait_done(d0 + 1);
    check("basic_count", rx_q.size(), 4);
    verify_burst(8'h10, 0, 4);
    check("basic_first_latency", first_valid_cyc - accept_cyc, 3);
    check("basic_back_to_back_words", last_hs_cyc - first_hs_cyc, 3);
    check("basic_done_latency", done_cyc - last_hs_cyc, 1);

    // Backpressure
    clear_stats();
    rdy_mode = 1;
    d0 = done_count;
    do_cmd(8'h40, 9'd8);
    wait_done(d0 + 1);
    rdy_mode = 0;
    check("bp_count", rx_q.size(), 8);
    verify_burst(8'h40, 0, 8);
    check("bp_stable", stable_err, 0);
    check("bp_overflow", overflow_err, 0);
    check("bp_max_count_le2", (max_cnt <= 2), 1);

    // Zero length
    clear_stats();
    d0 = done_count;
    do_cmd(8'h05, 9'd0);
    wait_done(d0 + 1);
    check("zero_count", rx_q.size(), 0);
    check("zero_done_latency", done_cyc - accept_cyc, 1);
    check("zero_busy", busy_seen, 0);
    check("zero_no_valid", (first_valid_cyc < 0), 1);

    // Wrap
    clear_stats();
    d0 = done_count;
    do_cmd(8'hFE, 9'd4);
    wait_done(d0 + 1);
    check("wrap_count", rx_q.size(), 4);
    verify_burst(8'hFE, 0, 4);

    // Full buffer
    clear_stats();
    d0 = done_count;
    do_cmd(8'h00, 9'd256);
    wait_done(d0 + 1);
    check("full_count", rx_q.size(), 256);
    check("full_last_count", last_cnt, 1);
    verify_burst(8'h00, 0, 256);

    // Reset mid-burst
    clear_stats();
    d0 = done_count;
    do_cmd(8'h80, 9'd16);
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      #1;
      if (rx_q.size() >= 5) break;
    end
    check("mid_words_before_reset", (rx_q.size() >= 5), 1);
    reset = 1'b1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_last", out_last, 0);
    check("mid_busy", busy, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_ram_address", ram_address, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid_no_done", done_count, d0);
    clear_stats();
    do_cmd(8'h20, 9'd2);
    wait_done(d0 + 1);
    check("post_rst_count", rx_q.size(), 2);
    verify_burst(8'h20, 0, 2);

    // Back-to-back commands with cmd_valid held
    clear_stats();
    d0 = done_count;
    do_cmd(8'h30, 9'd3);
    do_cmd(8'h60, 9'd3);
    check("b2b_accept_after_done", accept_cyc - done_cyc, 1);
    wait_done(d0 + 2);
    check("b2b_count", rx_q.size(), 6);
    check("b2b_last_count", last_cnt, 2);
    verify_burst(8'h30, 0, 3);
    verify_burst(8'h60, 3, 3);
    check("final_overflow", overflow_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
